// File: rtl/regex_stream_ctrl.sv
// Stream controller that feeds a bit string into a 1-cycle-latency regex engine
// and collects the match position, match count, string length and abort status.
module regex_stream_ctrl #(
  parameter int POS_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             anchored,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_last,
  output logic             s_ready,
  output logic             eng_reset,
  output logic             eng_i,
  output logic             eng_c,
  input  logic             eng_o,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_found,
  output logic [POS_W-1:0] m_pos,
  output logic [CNT_W-1:0] m_count,
  output logic [POS_W-1:0] m_len,
  output logic             m_err,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshakes: a bit transfers on a rising edge where s_valid && s_ready;
  // a result transfers on a rising edge where m_valid && m_ready. m_valid
  // and the m_* fields hold steady until that transfer.

  typedef enum logic [2:0] {IDLE, FLUSH, SCAN, DRAIN, REPORT} state_t;

  localparam logic [POS_W-1:0] LEN_LAST = {{(POS_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic             anch_q;
  logic             pend_q;
  logic [POS_W-1:0] pend_k;
  logic             accept;
  logic             sample;

  assign accept    = (state == SCAN) && s_valid;
  // eng_o belongs to the bit presented one cycle earlier, if any was.
  assign sample    = ((state == SCAN) || (state == DRAIN)) && pend_q && eng_o;

  assign s_ready   = (state == SCAN);
  assign busy      = (state != IDLE);
  assign m_valid   = (state == REPORT);
  assign eng_reset = reset || (state == FLUSH);
  assign eng_c     = accept && s_bit;
  assign eng_i     = accept && (!anch_q || (m_len == '0));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      anch_q  <= 1'b0;
      pend_q  <= 1'b0;
      pend_k  <= '0;
      m_found <= 1'b0;
      m_pos   <= '0;
      m_count <= '0;
      m_len   <= '0;
      m_err   <= 1'b0;
    end else begin
      if (sample) begin
        if (!m_found) begin
          m_found <= 1'b1;
          m_pos   <= pend_k;
        end
        if (m_count != '1) m_count <= m_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FLUSH;
            anch_q  <= anchored;
            m_found <= 1'b0;
            m_pos   <= '0;
            m_count <= '0;
            m_len   <= '0;
            m_err   <= 1'b0;
          end
        end
        FLUSH: begin
          pend_q <= 1'b0;
          state  <= SCAN;
        end
        SCAN: begin
          if (s_valid) begin
            pend_q <= 1'b1;
            pend_k <= m_len;
            m_len  <= m_len + POS_W'(1);
            if (s_last) begin
              state <= DRAIN;
            end else if (m_len == LEN_LAST) begin
              m_err <= 1'b1;
              state <= DRAIN;
            end
          end else begin
            // Gap: the engine step this cycle carries no real bit.
            pend_q <= 1'b0;
            m_err  <= 1'b1;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          pend_q <= 1'b0;
          state  <= REPORT;
        end
        REPORT: begin
          if (m_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regex_stream_ctrl.sv
// Directed bench for regex_stream_ctrl driving a behavioural engine for (0|1)*0.1
// ('.' = any bit); a 16-bit DUT is scoreboarded and a 4-bit DUT covers length limits.
module tb_regex_stream_ctrl;

  logic clk = 1'b0;
  logic reset, start, anchored, s_valid, s_bit, s_last, m_ready;
  always #5 clk = ~clk;

  logic        s_ready, eng_reset, eng_i, eng_c, eng_o, m_valid, m_found, m_err, busy;
  logic [15:0] m_pos, m_len;
  logic [7:0]  m_count;
  logic [2:0]  dbg_state;

  logic        w_s_ready, w_eng_reset, w_eng_i, w_eng_c, w_eng_o, w_m_valid, w_m_found, w_m_err, w_busy;
  logic [3:0]  w_m_pos, w_m_len;
  logic [7:0]  w_m_count;
  logic [2:0]  w_dbg_state;

  regex_stream_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .anchored(anchored),
    .s_valid(s_valid), .s_bit(s_bit), .s_last(s_last), .s_ready(s_ready),
    .eng_reset(eng_reset), .eng_i(eng_i), .eng_c(eng_c), .eng_o(eng_o),
    .m_valid(m_valid), .m_ready(m_ready), .m_found(m_found), .m_pos(m_pos),
    .m_count(m_count), .m_len(m_len), .m_err(m_err), .busy(busy), .dbg_state(dbg_state)
  );

  regex_stream_ctrl #(.POS_W(4), .CNT_W(8)) u_dut_w4 (
    .clk(clk), .reset(reset), .start(start), .anchored(anchored),
    .s_valid(s_valid), .s_bit(s_bit), .s_last(s_last), .s_ready(w_s_ready),
    .eng_reset(w_eng_reset), .eng_i(w_eng_i), .eng_c(w_eng_c), .eng_o(w_eng_o),
    .m_valid(w_m_valid), .m_ready(m_ready), .m_found(w_m_found), .m_pos(w_m_pos),
    .m_count(w_m_count), .m_len(w_m_len), .m_err(w_m_err), .busy(w_busy), .dbg_state(w_dbg_state)
  );

  // Engine NFA positions: a=(0|1)* loop, b='0', d='.', c='1' (final).
  logic ea, eb, ed, ec, force_o;
  always @(posedge clk) begin
    if (eng_reset) begin
      ea <= 1'b0; eb <= 1'b0; ed <= 1'b0; ec <= 1'b0;
    end else begin
      ea <= eng_i | ea;
      eb <= (eng_i | ea) & ~eng_c;
      ed <= eb;
      ec <= ed & eng_c;
    end
  end
  assign eng_o = ec | force_o;

  logic wa, wb, wd, wc;
  always @(posedge clk) begin
    if (w_eng_reset) begin
      wa <= 1'b0; wb <= 1'b0; wd <= 1'b0; wc <= 1'b0;
    end else begin
      wa <= w_eng_i | wa;
      wb <= (w_eng_i | wa) & ~w_eng_c;
      wd <= wb;
      wc <= wd & w_eng_c;
    end
  end
  assign w_eng_o = wc;

  int checks = 0;
  int failures = 0;
  logic [41:0] exp_q[$];
  logic cur_anch = 1'b0;
  int acc_k;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Result from the string rules: a match ends at k when bits[k-2]==0 and
  // bits[k]==1 (the start token at bit 0 always precedes k-2).
  function automatic logic [41:0] model_res(input logic [31:0] bits, input int n, input logic err);
    logic found;
    int pos, cnt;
    found = 1'b0; pos = 0; cnt = 0;
    for (int k = 2; k < n; k++) begin
      if (!bits[k-2] && bits[k]) begin
        if (!found) pos = k;
        found = 1'b1;
        if (cnt < 255) cnt++;
      end
    end
    return {found, 16'(pos), 8'(cnt), 16'(n), err};
  endfunction

  always @(posedge clk) begin
    if (reset || start) acc_k <= 0;
    else if (s_valid && s_ready) acc_k <= acc_k + 1;
  end

  // Per-cycle compare against the engine-token rules and the result scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (s_valid && s_ready) begin
        check("eng_c_bit", eng_c, s_bit);
        check("eng_i_bit", eng_i, cur_anch ? (acc_k == 0) : 1'b1);
      end else begin
        check("eng_i_quiet", eng_i, 1'b0);
        check("eng_c_quiet", eng_c, 1'b0);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", m_valid, 1'b0);
        end else begin
          check("result_fields", {m_found, m_pos, m_count, m_len, m_err}, exp_q[0]);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {s_ready, eng_i, eng_c, m_valid, m_found, m_err, busy}, 7'd0);
    check({tag, "_fields"}, {m_pos, m_count, m_len}, 40'd0);
    check({tag, "_eng_reset"}, eng_reset, 1'b1);
  endtask

  task automatic run_str(input logic anch, input logic [31:0] bits, input int n,
                         input bit last, input bit push, input bit force_drain);
    if (push) exp_q.push_back(model_res(bits, n, !last));
    cur_anch = anch;
    anchored = anch;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("flush_busy", busy, 1'b1);
    check("flush_eng_reset", eng_reset, 1'b1);
    check("flush_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    check("scan_s_ready", s_ready, 1'b1);
    check("scan_eng_reset", eng_reset, 1'b0);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_bit   = bits[i];
      s_last  = last && (i == n - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_bit = 1'b0; s_last = 1'b0;
    if (force_drain) begin
      @(posedge clk); #1;
      force_o = 1'b1;
      @(posedge clk); #1;
      force_o = 1'b0;
    end
  endtask

  task automatic wait_report();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (m_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("report_arrives", ok, 1'b1);
  endtask

  task automatic release_report();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("post_handshake_busy", busy, 1'b0);
    check("post_handshake_valid", m_valid, 1'b0);
  endtask

  logic [41:0] w_exp;

  initial begin
    reset = 1'b1; start = 1'b0; anchored = 1'b0; s_valid = 1'b0;
    s_bit = 1'b0; s_last = 1'b0; m_ready = 1'b0; force_o = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_eng_reset", eng_reset, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Unanchored "0,0,1"
    run_str(1'b0, 32'b100, 3, 1'b1, 1'b1, 1'b0);
    wait_report();
    check("t1_found", m_found, 1'b1);
    check("t1_pos", m_pos, 16'd2);
    check("t1_count", m_count, 8'd1);
    check("t1_len", m_len, 16'd3);
    check("t1_err", m_err, 1'b0);
    release_report();

    // Anchored "1,0,1": start token only with bit 0, no match
    run_str(1'b1, 32'b101, 3, 1'b1, 1'b1, 1'b0);
    wait_report();
    check("t2_found", m_found, 1'b0);
    check("t2_count", m_count, 8'd0);
    check("t2_len", m_len, 16'd3);
    release_report();

    // Gap after "0,1"; engine output forced high in the gap's attribution slot
    run_str(1'b0, 32'b10, 2, 1'b0, 1'b1, 1'b1);
    wait_report();
    check("t3_err", m_err, 1'b1);
    check("t3_len", m_len, 16'd2);
    check("t3_found", m_found, 1'b0);
    check("t3_count", m_count, 8'd0);
    release_report();

    // Two matches, result held 5 cycles while start pulses are ignored
    run_str(1'b0, 32'b110100, 6, 1'b1, 1'b1, 1'b0);
    wait_report();
    check("t4_pos", m_pos, 16'd2);
    check("t4_count", m_count, 8'd2);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      @(posedge clk); #1;
      check("t4_hold_valid", m_valid, 1'b1);
    end
    start = 1'b0;
    release_report();

    // Reset after 4 accepted bits abandons the string
    run_str(1'b0, 32'b1010, 4, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midscan_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("after_reset_valid", m_valid, 1'b0);
    check("after_reset_busy", busy, 1'b0);
    run_str(1'b1, 32'b100, 3, 1'b1, 1'b1, 1'b0);
    wait_report();
    check("t5_pos", m_pos, 16'd2);
    check("t5_len", m_len, 16'd3);
    release_report();

    // 15 bits ending in s_last: fills the 4-bit length exactly without error
    run_str(1'b0, 32'h00004B29, 15, 1'b1, 1'b1, 1'b0);
    wait_report();
    w_exp = model_res(32'h00004B29, 15, 1'b0);
    check("w4_full_valid", w_m_valid, 1'b1);
    check("w4_full_err", w_m_err, 1'b0);
    check("w4_full_len", w_m_len, 4'd15);
    check("w4_full_match", {w_m_found, 12'd0, w_m_pos, w_m_count}, w_exp[41:17]);
    release_report();
    check("w4_full_idle", w_busy, 1'b0);

    // 20 bits without s_last: 4-bit unit saturates at 15, 16-bit unit ends on the gap
    run_str(1'b0, 32'h000B4D2C, 20, 1'b0, 1'b1, 1'b0);
    w_exp = model_res(32'h000B4D2C, 15, 1'b1);
    check("w4_ovf_valid", w_m_valid, 1'b1);
    check("w4_ovf_err", w_m_err, 1'b1);
    check("w4_ovf_len", w_m_len, 4'd15);
    check("w4_ovf_match", {w_m_found, 12'd0, w_m_pos, w_m_count}, w_exp[41:17]);
    wait_report();
    check("t6_err", m_err, 1'b1);
    check("t6_len", m_len, 16'd20);
    release_report();
    check("w4_ovf_idle", w_busy, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
